stopwatch_ctrl: RTL and testbench

Control front-end for the board stopwatch counter (ms/s/min/h chain driving the four 7-segment digits). It debounces three push-buttons, runs a four-state run/pause/lap/idle machine, and drives the counter's run enable and clear. It also freezes a lap snapshot for the display path, so the seg7 decoders show either the live time or a held lap time while the counter keeps running.

---
 rtl/stopwatch_ctrl.sv | 158 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: button conditioning, run/pause/lap/idle machine,
// counter run/clear drive and lap-snapshot display path.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_startstop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic [9:0] cnt_ms,
  input  logic [5:0] cnt_sec,
  input  logic [5:0] cnt_min,
  output logic       run,
  output logic       clr,
  output logic       lap_hold,
  output logic [9:0] disp_ms,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [3:0] lap_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam int NBTN    = 3;
  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] press;

  assign btn_raw = {btn_clear, btn_lap, btn_startstop};

  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            press_reg;
      logic [DB_W-1:0] cnt_reg;

      // Any cycle where the synchronized input agrees with the accepted level restarts the count.
      always_ff @(posedge clk) begin
        if (!rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
            press_reg <= sync2_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  state_t     state_reg, state_next;
  logic [3:0] lap_count_reg, lap_count_next;
  logic       clr_reg, clr_next;
  logic       snap_take;
  logic       track;
  logic [9:0] disp_ms_reg;
  logic [5:0] disp_sec_reg;
  logic [5:0] disp_min_reg;

  // Each branch tests events in clear > startstop > lap order, skipping ones illegal in that state.
  always_comb begin
    state_next     = state_reg;
    lap_count_next = lap_count_reg;
    clr_next       = 1'b0;
    snap_take      = 1'b0;
    case (state_reg)
      IDLE, PAUSE: begin
        if (press[BTN_CLR]) begin
          state_next     = IDLE;
          clr_next       = 1'b1;
          lap_count_next = '0;
        end else if (press[BTN_SS]) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (press[BTN_SS]) begin
          state_next = PAUSE;
        end else if (press[BTN_LAP]) begin
          state_next     = LAP;
          lap_count_next = lap_count_reg + 4'd1;
          snap_take      = 1'b1;
        end
      end
      LAP: begin
        if (press[BTN_CLR]) begin
          state_next = RUN;
        end else if (press[BTN_SS]) begin
          state_next = PAUSE;
        end else if (press[BTN_LAP]) begin
          lap_count_next = lap_count_reg + 4'd1;
          snap_take      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The display registers double as the lap snapshot: they only stop loading while frozen.
  assign track = snap_take || (state_next != LAP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      lap_count_reg <= '0;
      clr_reg       <= 1'b0;
      disp_ms_reg   <= '0;
      disp_sec_reg  <= '0;
      disp_min_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      lap_count_reg <= lap_count_next;
      clr_reg       <= clr_next;
      if (track) begin
        disp_ms_reg  <= cnt_ms;
        disp_sec_reg <= cnt_sec;
        disp_min_reg <= cnt_min;
      end
    end
  end

  assign state     = state_reg;
  assign run       = (state_reg == RUN) || (state_reg == LAP);
  assign lap_hold  = (state_reg == LAP);
  assign clr       = clr_reg;
  assign lap_count = lap_count_reg;
  assign disp_ms   = disp_ms_reg;
  assign disp_sec  = disp_sec_reg;
  assign disp_min  = disp_min_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a rule-level reference model checked every cycle,
// plus literal expectations at the points the scenarios call out.
module tb_stopwatch_ctrl;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btns = 3'b111;  // [0] startstop, [1] lap, [2] clear
  logic [9:0] cnt_ms = '0;
  logic [5:0] cnt_sec = '0;
  logic [5:0] cnt_min = '0;
  logic       cnt_force = 1'b0;
  logic [9:0] f_ms = '0;
  logic [5:0] f_sec = '0;
  logic [5:0] f_min = '0;

  logic       run, clr, lap_hold;
  logic [9:0] disp_ms;
  logic [5:0] disp_sec, disp_min;
  logic [3:0] lap_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst(rst),
    .btn_startstop(btns[0]), .btn_lap(btns[1]), .btn_clear(btns[2]),
    .cnt_ms(cnt_ms), .cnt_sec(cnt_sec), .cnt_min(cnt_min),
    .run(run), .clr(clr), .lap_hold(lap_hold),
    .disp_ms(disp_ms), .disp_sec(disp_sec), .disp_min(disp_min),
    .lap_count(lap_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Free-running stand-in for the counter, updated on the falling edge.
  always @(negedge clk) begin
    if (cnt_force) begin
      cnt_ms  = f_ms;
      cnt_sec = f_sec;
      cnt_min = f_min;
    end else begin
      cnt_ms  = (cnt_ms >= 10'd993) ? cnt_ms - 10'd993 : cnt_ms + 10'd7;
      cnt_sec = (cnt_sec == 6'd59) ? 6'd0 : cnt_sec + 6'd1;
      if (cnt_sec == 6'd0) cnt_min = (cnt_min == 6'd59) ? 6'd0 : cnt_min + 6'd1;
    end
  end

  // Reference model: a button level is accepted once the 2-cycle-delayed raw input has held
  // one constant value, different from the accepted level, for N consecutive edges.
  logic       m_valid = 1'b0;
  logic [1:0] m_state;
  logic       m_clr;
  logic [3:0] m_laps;
  logic [9:0] m_ms;
  logic [5:0] m_sec, m_min;
  logic       m_h1[3], m_h2[3], m_dprev[3], m_lvl[3], m_ev[3];
  int         m_len[3];

  always @(posedge clk) begin
    logic       d;
    logic       a_clr, a_ss, a_lap;
    logic [1:0] ns;
    m_valid = 1'b1;
    if (!rst) begin
      m_state = 0; m_clr = 0; m_laps = 0; m_ms = 0; m_sec = 0; m_min = 0;
      for (int b = 0; b < 3; b++) begin
        m_h1[b] = 0; m_h2[b] = 0; m_dprev[b] = 0; m_lvl[b] = 0; m_ev[b] = 0; m_len[b] = 0;
      end
    end else begin
      a_clr = m_ev[2] && (m_state != 2'd1);
      a_ss  = !a_clr && m_ev[0];
      a_lap = !a_clr && !a_ss && m_ev[1] && (m_state == 2'd1 || m_state == 2'd3);
      ns = m_state;
      m_clr = 1'b0;
      if (a_clr) begin
        ns = (m_state == 2'd3) ? 2'd1 : 2'd0;
        if (m_state != 2'd3) begin
          m_clr = 1'b1;
          m_laps = 0;
        end
      end else if (a_ss) begin
        ns = (m_state == 2'd1 || m_state == 2'd3) ? 2'd2 : 2'd1;
      end else if (a_lap) begin
        ns = 2'd3;
        m_laps = m_laps + 4'd1;
      end
      if (a_lap || ns != 2'd3) begin
        m_ms = cnt_ms; m_sec = cnt_sec; m_min = cnt_min;
      end
      m_state = ns;
      for (int b = 0; b < 3; b++) begin
        d = m_h2[b];
        m_h2[b] = m_h1[b];
        m_h1[b] = btns[b];
        m_len[b] = (d == m_dprev[b]) ? m_len[b] + 1 : 1;
        m_dprev[b] = d;
        m_ev[b] = 1'b0;
        if (d != m_lvl[b] && m_len[b] >= N) begin
          m_lvl[b] = d;
          m_ev[b] = d;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid)
      check("cycle", {1'b0, state, run, clr, lap_hold, lap_count, disp_min, disp_sec, disp_ms},
            {1'b0, m_state, (m_state == 2'd1 || m_state == 2'd3), m_clr, (m_state == 2'd3),
             m_laps, m_min, m_sec, m_ms});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] m);
    btns = btns | m;
    step(N + 3);
  endtask

  task automatic release_all();
    btns = 3'b000;
    step(N + 4);
  endtask

  initial begin
    logic [9:0] cap;

    // Reset with all buttons held
    step(3);
    check("reset_outputs", {state, run, clr, lap_hold, lap_count, disp_min, disp_sec, disp_ms}, 32'd0);
    rst = 1'b1;
    step(N + 2);
    check("post_reset_quiet_clr", clr, 0);
    check("post_reset_quiet_state", state, 0);
    step(1);
    check("post_reset_clear_pulse", clr, 1);
    check("post_reset_idle", state, 0);
    step(1);
    check("post_reset_clr_end", clr, 0);
    release_all();
    $display("txn reset: state=%0d lap_count=%0d", state, lap_count);

    // Bouncing startstop
    for (int i = 0; i < 20; i++) begin
      btns[0] = (i % 2 == 0);
      step(5);
    end
    check("bounce_no_event", state, 0);
    btns[0] = 1'b1;
    step(N + 2);
    check("debounce_before", state, 0);
    step(1);
    check("debounce_state", state, 1);
    check("debounce_run", run, 1);
    step(30);
    check("held_single_event", state, 1);
    release_all();
    $display("txn debounce: state=%0d run=%0d", state, run);

    // Pause then clear
    press(3'b001);
    check("pause_state", state, 2);
    check("pause_run", run, 0);
    release_all();
    btns = 3'b100;
    step(N + 2);
    check("clear_pre_clr", clr, 0);
    step(1);
    check("clear_state", state, 0);
    check("clear_clr_on", clr, 1);
    step(1);
    check("clear_clr_off", clr, 0);
    release_all();
    $display("txn run_pause_clear: state=%0d", state);

    // Lap freeze
    press(3'b001);
    release_all();
    f_min = 6'd3; f_sec = 6'd12; f_ms = 10'd345; cnt_force = 1'b1;
    press(3'b010);
    cnt_force = 1'b0;
    check("lap1_state", state, 3);
    check("lap1_hold", lap_hold, 1);
    check("lap1_sec", disp_sec, 12);
    check("lap1_ms", disp_ms, 345);
    check("lap1_count", lap_count, 1);
    release_all();
    check("lap1_still_held", disp_ms, 345);
    f_sec = 6'd20; f_ms = 10'd500; cnt_force = 1'b1;
    press(3'b010);
    cnt_force = 1'b0;
    check("lap2_sec", disp_sec, 20);
    check("lap2_count", lap_count, 2);
    release_all();
    btns = 3'b100;
    step(N + 2);
    check("lapclr_pre", state, 3);
    step(1);
    check("lapclr_state", state, 1);
    check("lapclr_hold", lap_hold, 0);
    check("lapclr_clr", clr, 0);
    @(negedge clk); #1;
    cap = cnt_ms;
    step(1);
    check("lapclr_track", disp_ms, cap);
    check("lapclr_clr_next", clr, 0);
    release_all();
    $display("txn lap: state=%0d lap_count=%0d", state, lap_count);

    // Simultaneous events
    press(3'b011);
    check("lapss_state", state, 2);
    check("lapss_count", lap_count, 2);
    release_all();
    press(3'b101);
    check("clrss_state", state, 0);
    check("clrss_clr", clr, 1);
    check("clrss_run", run, 0);
    release_all();
    $display("txn simultaneous: state=%0d lap_count=%0d", state, lap_count);

    // Lap wrap, then reset mid-debounce while in LAP
    press(3'b001);
    release_all();
    for (int i = 1; i <= 16; i++) begin
      press(3'b010);
      check("wrap_count", lap_count, 32'(i % 16));
      release_all();
    end
    for (int i = 0; i < 5; i++) begin
      press(3'b010);
      release_all();
    end
    check("pre_reset_count", lap_count, 5);
    check("pre_reset_state", state, 3);
    btns[0] = 1'b1;
    step(8);
    rst = 1'b0;
    step(1);
    check("rst_mid_outputs", {state, run, clr, lap_hold, lap_count, disp_min, disp_sec, disp_ms}, 32'd0);
    rst = 1'b1;
    btns = 3'b000;
    step(N + 4);
    check("rst_press_discarded", state, 0);
    $display("txn wrap_reset: state=%0d lap_count=%0d", state, lap_count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
